// File: rtl/memory_dp_masked_pkg.sv
// Shared definitions for the masked dual-port memory and its clear sequencer.
//   RD_MODE_*   : read-during-write behaviour selectors for the RD_MODE parameter
//   clr_state_e : clear sequencer states (IDLE = array free, CLEAR = sweep running)
package memory_dp_masked_pkg;

  localparam int unsigned RD_MODE_READ_FIRST  = 0;
  localparam int unsigned RD_MODE_WRITE_FIRST = 1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_e;

endpackage

// File: rtl/memory_dp_masked_clear_seq.sv
// Clear sequencer: walks every address once, asking the top to write FILL_VALUE.
// Ports:
//   clk_i      in   clock, state advances on the falling edge
//   reset_i    in   synchronous active-high reset
//   clear_i    in   start a sweep (only taken while idle)
//   busy_o     out  1 while the sweep owns the array
//   clr_we_o   out  write strobe for the sweep (same timing as busy_o)
//   clr_addr_o out  address being filled on the coming edge
module memory_dp_masked_clear_seq
  import memory_dp_masked_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 8,
  parameter int unsigned CLEAR_ON_RESET = 0
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  clear_i,
  output logic                  busy_o,
  output logic                  clr_we_o,
  output logic [ADDR_WIDTH-1:0] clr_addr_o
);

  clr_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;

  // State register; a reset mid-sweep restarts from address 0 or drops to idle.
  always_ff @(negedge clk_i) begin
    if (reset_i) begin
      state_q    <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
      clr_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
    end
  end

  // Next state: the sweep ends after the edge that fills the last address.
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    case (state_q)
      ST_IDLE: begin
        if (clear_i) begin
          state_d    = ST_CLEAR;
          clr_addr_d = '0;
        end
      end
      ST_CLEAR: begin
        clr_addr_d = clr_addr_q + ADDR_WIDTH'(1);
        if (&clr_addr_q) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy_o     = (state_q == ST_CLEAR);
  assign clr_we_o   = (state_q == ST_CLEAR);
  assign clr_addr_o = clr_addr_q;

endmodule

// File: rtl/memory_dp_masked.sv
// Dual-port memory with per-lane write mask, selectable read-during-write
// behaviour and a hardware clear sweep. All state changes on the falling edge.
// Ports:
//   clk_i      in   clock (falling-edge active)
//   reset_i    in   synchronous active-high reset
//   wr_en_i    in   write request
//   wr_addr_i  in   write address
//   wr_data_i  in   write data
//   wr_mask_i  in   lane enables, lane k covers bits [k*LANE_WIDTH +: LANE_WIDTH]
//   rd_en_i    in   read request
//   rd_addr_i  in   read address
//   rd_data_o  out  registered read data, holds when no read is taken
//   rd_valid_o out  one-cycle pulse when rd_data_o was updated
//   clear_i    in   start a clear sweep (idle only)
//   busy_o     out  clear sweep in progress; user traffic is dropped
module memory_dp_masked
  import memory_dp_masked_pkg::*;
#(
  parameter int unsigned            ADDR_WIDTH     = 8,
  parameter int unsigned            DATA_WIDTH     = 16,
  parameter int unsigned            LANE_WIDTH     = 8,
  parameter int unsigned            RD_MODE        = RD_MODE_READ_FIRST,
  parameter int unsigned            CLEAR_ON_RESET = 0,
  parameter logic [DATA_WIDTH-1:0]  FILL_VALUE     = '0,
  parameter string                  INIT_FILE      = "",
  localparam int unsigned           LANES          = DATA_WIDTH / LANE_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  wr_en_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic [LANES-1:0]      wr_mask_i,
  input  logic                  rd_en_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  rd_valid_o,
  input  logic                  clear_i,
  output logic                  busy_o
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  if (DATA_WIDTH % LANE_WIDTH != 0) begin : g_lane_check
    $error("memory_dp_masked: DATA_WIDTH must be a multiple of LANE_WIDTH");
  end

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                  clr_busy;
  logic                  clr_we;
  logic [ADDR_WIDTH-1:0] clr_addr;

  memory_dp_masked_clear_seq #(
    .ADDR_WIDTH     (ADDR_WIDTH),
    .CLEAR_ON_RESET (CLEAR_ON_RESET)
  ) u_clear_seq (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .clear_i    (clear_i),
    .busy_o     (clr_busy),
    .clr_we_o   (clr_we),
    .clr_addr_o (clr_addr)
  );

  // User traffic is dropped on reset edges, during a sweep, and on the edge a sweep starts.
  logic user_ok_c;
  assign user_ok_c = !reset_i && !clr_busy && !clear_i;

  // Single write port shared between the sweep and the user.
  logic                  we_c;
  logic [ADDR_WIDTH-1:0] waddr_c;
  logic [DATA_WIDTH-1:0] wdata_c;
  logic [LANES-1:0]      wmask_c;

  always_comb begin
    we_c    = 1'b0;
    waddr_c = wr_addr_i;
    wdata_c = wr_data_i;
    wmask_c = wr_mask_i;
    if (clr_we && !reset_i) begin
      we_c    = 1'b1;
      waddr_c = clr_addr;
      wdata_c = FILL_VALUE;
      wmask_c = '1;
    end else if (user_ok_c && wr_en_i) begin
      we_c = 1'b1;
    end
  end

  // Byte-enable style lane writes.
  always_ff @(negedge clk_i) begin
    if (we_c) begin
      for (int k = 0; k < LANES; k++) begin
        if (wmask_c[k]) begin
          mem_q[waddr_c][k*LANE_WIDTH +: LANE_WIDTH] <= wdata_c[k*LANE_WIDTH +: LANE_WIDTH];
        end
      end
    end
  end

  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  rd_valid_q, rd_valid_d;

  // Read path; in write-first mode a same-address write overrides its masked lanes.
  always_comb begin
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    if (user_ok_c && rd_en_i) begin
      rd_valid_d = 1'b1;
      rd_data_d  = mem_q[rd_addr_i];
      if ((RD_MODE == RD_MODE_WRITE_FIRST) && wr_en_i && (wr_addr_i == rd_addr_i)) begin
        for (int k = 0; k < LANES; k++) begin
          if (wr_mask_i[k]) begin
            rd_data_d[k*LANE_WIDTH +: LANE_WIDTH] = wr_data_i[k*LANE_WIDTH +: LANE_WIDTH];
          end
        end
      end
    end
  end

  always_ff @(negedge clk_i) begin
    if (reset_i) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign rd_data_o  = rd_data_q;
  assign rd_valid_o = rd_valid_q;
  assign busy_o     = clr_busy;

endmodule

// File: tb/tb_memory_dp_masked.sv
// Bench for memory_dp_masked: two 256x16 instances sharing stimulus
// (read-first with clear-on-reset, write-first without) checked against an
// array model every cycle, plus a 1024x32 instance for the wide-lane case.
module tb_memory_dp_masked;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_i, wr_en, rd_en, clear;
  logic [7:0]  wr_addr, rd_addr;
  logic [15:0] wr_data;
  logic [1:0]  wr_mask;
  logic [15:0] rd_data0, rd_data1;
  logic        vld0, vld1, busy0, busy1;

  logic        wr_en2, rd_en2, clear2;
  logic [9:0]  wr_addr2, rd_addr2;
  logic [31:0] wr_data2, rd_data2;
  logic [3:0]  wr_mask2;
  logic        vld2, busy2;

  memory_dp_masked #(
    .ADDR_WIDTH(8), .DATA_WIDTH(16), .LANE_WIDTH(8), .RD_MODE(0),
    .CLEAR_ON_RESET(1), .FILL_VALUE(16'hDEAD), .INIT_FILE("")
  ) u_dut0 (
    .clk_i(clk), .reset_i(reset_i), .wr_en_i(wr_en), .wr_addr_i(wr_addr),
    .wr_data_i(wr_data), .wr_mask_i(wr_mask), .rd_en_i(rd_en), .rd_addr_i(rd_addr),
    .rd_data_o(rd_data0), .rd_valid_o(vld0), .clear_i(clear), .busy_o(busy0)
  );

  memory_dp_masked #(
    .ADDR_WIDTH(8), .DATA_WIDTH(16), .LANE_WIDTH(8), .RD_MODE(1),
    .CLEAR_ON_RESET(0), .FILL_VALUE(16'h5A5A), .INIT_FILE("")
  ) u_dut1 (
    .clk_i(clk), .reset_i(reset_i), .wr_en_i(wr_en), .wr_addr_i(wr_addr),
    .wr_data_i(wr_data), .wr_mask_i(wr_mask), .rd_en_i(rd_en), .rd_addr_i(rd_addr),
    .rd_data_o(rd_data1), .rd_valid_o(vld1), .clear_i(clear), .busy_o(busy1)
  );

  memory_dp_masked #(
    .ADDR_WIDTH(10), .DATA_WIDTH(32), .LANE_WIDTH(8), .RD_MODE(0),
    .CLEAR_ON_RESET(0), .FILL_VALUE(32'h0), .INIT_FILE("")
  ) u_dut2 (
    .clk_i(clk), .reset_i(reset_i), .wr_en_i(wr_en2), .wr_addr_i(wr_addr2),
    .wr_data_i(wr_data2), .wr_mask_i(wr_mask2), .rd_en_i(rd_en2), .rd_addr_i(rd_addr2),
    .rd_data_o(rd_data2), .rd_valid_o(vld2), .clear_i(clear2), .busy_o(busy2)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model per 256x16 instance: plain word array plus a sweep counter.
  logic [15:0] ref_mem [2][256];
  logic [15:0] ref_rd   [2];
  bit          ref_vld  [2];
  bit          ref_busy [2];
  int          ref_left [2];
  bit          cfg_wfirst [2] = '{1'b0, 1'b1};
  bit          cfg_cor    [2] = '{1'b1, 1'b0};
  logic [15:0] cfg_fill   [2] = '{16'hDEAD, 16'h5A5A};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One edge of behaviour for instance i, using the inputs presented this cycle.
  task automatic model_edge(input int i);
    logic [15:0] lane_m, merged, old_rd;
    if (reset_i) begin
      ref_rd[i]   = '0;
      ref_vld[i]  = 1'b0;
      ref_busy[i] = cfg_cor[i];
      ref_left[i] = 256;
    end else if (ref_busy[i]) begin
      ref_mem[i][256 - ref_left[i]] = cfg_fill[i];
      ref_left[i] = ref_left[i] - 1;
      ref_busy[i] = (ref_left[i] != 0);
      ref_vld[i]  = 1'b0;
    end else if (clear) begin
      ref_busy[i] = 1'b1;
      ref_left[i] = 256;
      ref_vld[i]  = 1'b0;
    end else begin
      lane_m = {{8{wr_mask[1]}}, {8{wr_mask[0]}}};
      merged = (ref_mem[i][wr_addr] & ~lane_m) | (wr_data & lane_m);
      old_rd = ref_mem[i][rd_addr];
      ref_vld[i] = rd_en;
      if (rd_en) begin
        ref_rd[i] = (cfg_wfirst[i] && wr_en && (wr_addr == rd_addr)) ? merged : old_rd;
      end
      if (wr_en) begin
        ref_mem[i][wr_addr] = merged;
      end
    end
  endtask

  // Advance the model and the DUTs by one falling edge, then check on the rising edge.
  task automatic cycle();
    model_edge(0);
    model_edge(1);
    @(negedge clk);
    @(posedge clk);
    chk("busy0", 32'(busy0), 32'(ref_busy[0]));
    chk("busy1", 32'(busy1), 32'(ref_busy[1]));
    chk("vld0", 32'(vld0), 32'(ref_vld[0]));
    chk("vld1", 32'(vld1), 32'(ref_vld[1]));
    chk("rd0", 32'(rd_data0), 32'(ref_rd[0]));
    chk("rd1", 32'(rd_data1), 32'(ref_rd[1]));
  endtask

  task automatic idle();
    wr_en = 1'b0; rd_en = 1'b0; clear = 1'b0;
    wr_addr = '0; rd_addr = '0; wr_data = '0; wr_mask = '0;
  endtask

  task automatic rand_ops();
    wr_en   = 1'($urandom_range(0, 1));
    wr_addr = 8'($urandom_range(0, 15));
    wr_data = 16'($urandom);
    wr_mask = 2'($urandom_range(0, 3));
    rd_en   = 1'($urandom_range(0, 1));
    rd_addr = ($urandom_range(0, 1) == 1) ? wr_addr : 8'($urandom_range(0, 15));
  endtask

  int c0, c1, guard;

  initial begin
    idle();
    reset_i = 1'b1;
    wr_en2 = 1'b0; rd_en2 = 1'b0; clear2 = 1'b0;
    wr_addr2 = '0; rd_addr2 = '0; wr_data2 = '0; wr_mask2 = '0;

    // Reset: dut0 starts its sweep, dut1 idles; clear dut1 so both are defined.
    c0 = 0; c1 = 0; guard = 0;
    cycle();
    c0 += int'(busy0); c1 += int'(busy1);
    reset_i = 1'b0;
    clear = 1'b1;
    cycle();
    c0 += int'(busy0); c1 += int'(busy1);
    clear = 1'b0;
    while ((busy0 || busy1) && guard < 600) begin
      cycle();
      c0 += int'(busy0); c1 += int'(busy1);
      guard++;
    end
    chk("init_clr_len0", 32'(c0), 32'd256);
    chk("init_clr_len1", 32'(c1), 32'd256);

    // First read after the sweeps.
    idle(); rd_en = 1'b1; rd_addr = 8'h05;
    cycle();
    chk("t1_rd0", 32'(rd_data0), 32'h0000DEAD);
    chk("t1_rd1", 32'(rd_data1), 32'h00005A5A);
    chk("t1_vld0", 32'(vld0), 32'd1);

    // Masked overwrite of one lane.
    idle(); wr_en = 1'b1; wr_addr = 8'h10; wr_data = 16'hABCD; wr_mask = 2'b11;
    cycle();
    wr_data = 16'h1234; wr_mask = 2'b01;
    cycle();
    idle(); rd_en = 1'b1; rd_addr = 8'h10;
    cycle();
    chk("t2_rd0", 32'(rd_data0), 32'h0000AB34);
    chk("t2_rd1", 32'(rd_data1), 32'h0000AB34);
    idle();
    cycle();
    chk("t2_hold0", 32'(rd_data0), 32'h0000AB34);
    chk("t2_novld0", 32'(vld0), 32'd0);

    // Read-during-write on the same address.
    idle(); wr_en = 1'b1; wr_addr = 8'h20; wr_data = 16'h1111; wr_mask = 2'b11;
    cycle();
    wr_data = 16'h2222; rd_en = 1'b1; rd_addr = 8'h20;
    cycle();
    chk("t3_rf0", 32'(rd_data0), 32'h00001111);
    chk("t3_wf1", 32'(rd_data1), 32'h00002222);
    idle(); rd_en = 1'b1; rd_addr = 8'h20;
    cycle();
    chk("t3_after0", 32'(rd_data0), 32'h00002222);
    chk("t3_after1", 32'(rd_data1), 32'h00002222);

    // Wide instance: lane mask over a zero word.
    idle();
    wr_en2 = 1'b1; wr_addr2 = 10'h3FF; wr_data2 = 32'h0; wr_mask2 = 4'hF;
    cycle();
    wr_data2 = 32'hCAFEBABE; wr_mask2 = 4'b1010;
    cycle();
    wr_en2 = 1'b0; rd_en2 = 1'b1; rd_addr2 = 10'h3FF;
    cycle();
    chk("t6_rd2", rd_data2, 32'hCA00BA00);
    chk("t6_vld2", 32'(vld2), 32'd1);
    rd_en2 = 1'b0;
    cycle();
    chk("t6_novld2", 32'(vld2), 32'd0);
    chk("t6_busy2", 32'(busy2), 32'd0);

    // Randomised traffic with occasional clears.
    for (int n = 0; n < 400; n++) begin
      rand_ops();
      clear = ($urandom_range(0, 149) == 0);
      cycle();
    end
    idle();
    guard = 0;
    while ((busy0 || busy1) && guard < 600) begin
      cycle();
      guard++;
    end

    // Fill with data, clear, traffic during the sweep must be dropped.
    for (int a = 0; a < 256; a++) begin
      wr_en = 1'b1; wr_addr = 8'(a); wr_data = 16'($urandom); wr_mask = 2'b11; rd_en = 1'b0;
      cycle();
    end
    idle(); clear = 1'b1;
    cycle();
    c0 = int'(busy0); c1 = int'(busy1); guard = 0;
    clear = 1'b0;
    while ((busy0 || busy1) && guard < 600) begin
      rand_ops();
      cycle();
      c0 += int'(busy0); c1 += int'(busy1);
      guard++;
    end
    chk("t4_clr_len0", 32'(c0), 32'd256);
    chk("t4_clr_len1", 32'(c1), 32'd256);
    for (int a = 0; a < 256; a++) begin
      idle(); rd_en = 1'b1; rd_addr = 8'(a);
      cycle();
      chk("t4_fill0", 32'(rd_data0), 32'h0000DEAD);
      chk("t4_fill1", 32'(rd_data1), 32'h00005A5A);
    end

    // Scribble data, then reset halfway through a sweep.
    for (int a = 0; a < 256; a++) begin
      wr_en = 1'b1; wr_addr = 8'(a); wr_data = 16'($urandom); wr_mask = 2'($urandom_range(1, 3)); rd_en = 1'b0;
      cycle();
    end
    idle(); clear = 1'b1;
    cycle();
    clear = 1'b0;
    for (int n = 0; n < 128; n++) cycle();
    reset_i = 1'b1;
    cycle();
    chk("t5_rst_busy0", 32'(busy0), 32'd1);
    chk("t5_rst_busy1", 32'(busy1), 32'd0);
    chk("t5_rst_rd0", 32'(rd_data0), 32'd0);
    c0 = int'(busy0); guard = 0;
    reset_i = 1'b0;
    while (busy0 && guard < 600) begin
      rand_ops();
      cycle();
      c0 += int'(busy0);
      guard++;
    end
    chk("t5_clr_len0", 32'(c0), 32'd256);
    for (int a = 0; a < 256; a++) begin
      idle(); rd_en = 1'b1; rd_addr = 8'(a);
      cycle();
      chk("t5_fill0", 32'(rd_data0), 32'h0000DEAD);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
